// File: rtl/pe_array_16.sv
// Q4.12 SIMD processing-element array: per-lane MUL/MAC/ADD/HOLD into a saturating accumulator.
// Latency: result is visible one edge after the operation. Backpressure: none, so a new op is accepted every cycle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef MODE_MUL
`define MODE_MUL  2'b00
`define MODE_MAC  2'b01
`define MODE_ADD  2'b10
`define MODE_HOLD 2'b11
`endif

module pe_array_16 #(
  parameter int LANES = 16,
  parameter int DW    = `DATA_WIDTH,
  parameter int FRAC  = 12,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            pe_op_mode_in,
  input  logic                  pe_clear_in,
  input  logic [LANES*DW-1:0]   pe_in_a_vec,
  input  logic [LANES*DW-1:0]   pe_in_b_vec,
  output logic [LANES*DW-1:0]   pe_result_vec,
  output logic [LANES-1:0]      pe_sat_vec,
  output logic                  pe_result_valid
);

  localparam logic [1:0] MODE_MUL  = `MODE_MUL;
  localparam logic [1:0] MODE_MAC  = `MODE_MAC;
  localparam logic [1:0] MODE_ADD  = `MODE_ADD;
  localparam logic [1:0] MODE_HOLD = `MODE_HOLD;

  localparam int PW = 2 * DW;

  // Output range of a DW-bit result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [PW:0]      RND     = {{(PW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic op_en;
  logic valid_q;

  assign op_en           = !pe_clear_in && (pe_op_mode_in != MODE_HOLD);
  assign pe_result_valid = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else if (pe_clear_in) begin
      valid_q <= 1'b0;
    end else if (op_en) begin
      valid_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [DW-1:0]    a;
    logic signed [DW-1:0]    b;
    logic signed [PW:0]      prod;
    logic signed [PW:0]      prod_rnd;
    logic signed [ACC_W:0]   p_ext;
    logic signed [ACC_W:0]   a_ext;
    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   sum;
    logic                    ovf;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic                    sat_d;
    logic                    sat_q;

    always_comb begin
      a        = pe_in_a_vec[i*DW +: DW];
      b        = pe_in_b_vec[i*DW +: DW];
      // One guard bit above the full product keeps the rounding add from wrapping.
      prod     = (PW+1)'(a) * (PW+1)'(b);
      prod_rnd = (prod + RND) >>> FRAC;
      p_ext    = (ACC_W+1)'(prod_rnd);
      a_ext    = (ACC_W+1)'(a);
      acc_ext  = (ACC_W+1)'(acc_q);
      case (pe_op_mode_in)
        MODE_MUL: sum = p_ext;
        MODE_MAC: sum = acc_ext + p_ext;
        MODE_ADD: sum = acc_ext + a_ext;
        default:  sum = acc_ext;
      endcase
      ovf   = sum[ACC_W] != sum[ACC_W-1];
      acc_d = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
      sat_d = sat_q || ovf || (acc_d > RES_MAX) || (acc_d < RES_MIN);
    end

    always_ff @(posedge clk) begin
      if (reset || pe_clear_in) begin
        acc_q <= '0;
        sat_q <= 1'b0;
      end else if (op_en) begin
        acc_q <= acc_d;
        sat_q <= sat_d;
      end
    end

    assign pe_sat_vec[i] = sat_q;
    assign pe_result_vec[i*DW +: DW] = (acc_q > RES_MAX) ? RES_MAX[DW-1:0] :
                                       (acc_q < RES_MIN) ? RES_MIN[DW-1:0] :
                                                           acc_q[DW-1:0];
  end

endmodule

// File: tb/tb_pe_array_16.sv
// Directed bench for pe_array_16: hand-computed Q4.12 vectors checked one edge after each op.
module tb_pe_array_16;
  localparam int LANES = 16;
  localparam int DW    = 16;
  localparam logic [1:0] M_MUL  = 2'b00;
  localparam logic [1:0] M_MAC  = 2'b01;
  localparam logic [1:0] M_ADD  = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [1:0]            mode = M_HOLD;
  logic                  clear = 1'b0;
  logic [LANES*DW-1:0]   a_vec = '0;
  logic [LANES*DW-1:0]   b_vec = '0;
  logic [LANES*DW-1:0]   res_vec;
  logic [LANES-1:0]      sat_vec;
  logic                  valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pe_array_16 dut (
    .clk             (clk),
    .reset           (reset),
    .pe_op_mode_in   (mode),
    .pe_clear_in     (clear),
    .pe_in_a_vec     (a_vec),
    .pe_in_b_vec     (b_vec),
    .pe_result_vec   (res_vec),
    .pe_sat_vec      (sat_vec),
    .pe_result_valid (valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < LANES; i++) begin
      a_vec[i*DW +: DW] = a;
      b_vec[i*DW +: DW] = b;
    end
  endtask

  task automatic set_lane(input int i, input logic [15:0] a, input logic [15:0] b);
    a_vec[i*DW +: DW] = a;
    b_vec[i*DW +: DW] = b;
  endtask

  // Drive one operation, let it take effect on the edge, sample 1 time unit later.
  task automatic step(input logic [1:0] m, input logic c);
    mode  = m;
    clear = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lane_res(input int i);
    return res_vec[i*DW +: DW];
  endfunction

  initial begin
    // Reset state
    reset = 1'b1;
    set_all(16'h1234, 16'h5678);
    step(M_MUL, 1'b0);
    step(M_MUL, 1'b0);
    check("rst_res_any", {31'b0, |res_vec}, 32'h0);
    check("rst_sat", {16'b0, sat_vec}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    reset = 1'b0;

    // Bias load then MAC
    set_all(16'h0100, 16'h1000);
    step(M_MUL, 1'b0);
    check("bias_mul", {16'b0, lane_res(0)}, 32'h0100);
    check("bias_valid", {31'b0, valid}, 32'h1);
    set_all(16'h1000, 16'h2000);
    step(M_MAC, 1'b0);
    check("bias_mac", {16'b0, lane_res(0)}, 32'h2100);
    check("bias_mac_valid", {31'b0, valid}, 32'h1);

    // Round-half-up on the product
    set_all(16'h0001, 16'h0800);
    step(M_MUL, 1'b0);
    check("rnd_pos_half", {16'b0, lane_res(0)}, 32'h0001);
    set_all(16'hFFFF, 16'h0800);
    step(M_MUL, 1'b0);
    check("rnd_neg_half", {16'b0, lane_res(0)}, 32'h0000);
    set_all(16'hFFFF, 16'h0FFF);
    step(M_MUL, 1'b0);
    check("rnd_neg_small", {16'b0, lane_res(0)}, 32'hFFFF);

    // Saturation on lane 0 only; sat is sticky until clear
    set_all(16'h1000, 16'h0100);
    set_lane(0, 16'h7FFF, 16'h7FFF);
    step(M_MUL, 1'b0);
    check("sat_res0", {16'b0, lane_res(0)}, 32'h7FFF);
    check("sat_flag0", {31'b0, sat_vec[0]}, 32'h1);
    check("sat_res1", {16'b0, lane_res(1)}, 32'h0100);
    check("sat_flag_others", {16'b0, sat_vec}, 32'h0001);
    set_all(16'h0000, 16'h0000);
    step(M_MUL, 1'b0);
    check("sat_back_res0", {16'b0, lane_res(0)}, 32'h0000);
    check("sat_sticky0", {31'b0, sat_vec[0]}, 32'h1);
    step(M_MUL, 1'b1);
    check("sat_clr_flag", {16'b0, sat_vec}, 32'h0);
    check("sat_clr_valid", {31'b0, valid}, 32'h0);

    // Negative saturation clamps to 0x8000 on every lane
    set_all(16'h8000, 16'h7FFF);
    step(M_MUL, 1'b0);
    check("negsat_res5", {16'b0, lane_res(5)}, 32'h8000);
    check("negsat_flags", {16'b0, sat_vec}, 32'hFFFF);
    step(M_HOLD, 1'b1);

    // Clear beats MAC, reset beats MUL, reset discards the accumulation
    set_all(16'h1000, 16'h1000);
    step(M_MUL, 1'b0);
    check("prio_pre", {16'b0, lane_res(0)}, 32'h1000);
    step(M_MAC, 1'b1);
    check("prio_clr_res", {16'b0, lane_res(0)}, 32'h0);
    check("prio_clr_valid", {31'b0, valid}, 32'h0);
    step(M_MUL, 1'b0);
    reset = 1'b1;
    step(M_MUL, 1'b0);
    reset = 1'b0;
    check("prio_rst_res_any", {31'b0, |res_vec}, 32'h0);
    check("prio_rst_sat", {16'b0, sat_vec}, 32'h0);
    check("prio_rst_valid", {31'b0, valid}, 32'h0);
    set_all(16'h1000, 16'h2000);
    step(M_MAC, 1'b0);
    check("post_rst_mac", {16'b0, lane_res(0)}, 32'h2000);

    // HOLD ignores operands, ADD sign-extends a
    set_all(16'h0400, 16'h1000);
    step(M_MUL, 1'b0);
    check("ha_mul", {16'b0, lane_res(0)}, 32'h0400);
    set_all(16'h7FFF, 16'h7FFF);
    step(M_HOLD, 1'b0);
    check("ha_hold", {16'b0, lane_res(0)}, 32'h0400);
    set_all(16'h0100, 16'h7FFF);
    step(M_ADD, 1'b0);
    check("ha_add", {16'b0, lane_res(0)}, 32'h0500);
    set_all(16'hFF00, 16'h0000);
    step(M_ADD, 1'b0);
    check("ha_add_neg", {16'b0, lane_res(0)}, 32'h0400);

    // conv1d pattern: bias (i+1)*0x10, then 4 MACs of 0.5 * odd b rounding up
    // to i*0x10+k+1, so lane i ends at 0x50*i + 0x1A.
    step(M_HOLD, 1'b1);
    for (int i = 0; i < LANES; i++) set_lane(i, 16'((i + 1) * 16), 16'h1000);
    step(M_MUL, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LANES; i++) set_lane(i, 16'h0800, 16'(i * 32 + 2 * k + 1));
      step(M_MAC, 1'b0);
    end
    for (int i = 0; i < LANES; i++)
      check($sformatf("conv_l%0d", i), {16'b0, lane_res(i)}, 32'(16'h50 * i + 16'h1A));
    set_all(16'h0000, 16'h0000);
    step(M_MAC, 1'b0);
    for (int i = 0; i < LANES; i++)
      check($sformatf("conv_hold1_l%0d", i), {16'b0, lane_res(i)}, 32'(16'h50 * i + 16'h1A));
    set_all(16'h0000, 16'h0000);
    step(M_MAC, 1'b0);
    for (int i = 0; i < LANES; i++)
      check($sformatf("conv_hold2_l%0d", i), {16'b0, lane_res(i)}, 32'(16'h50 * i + 16'h1A));
    check("conv_sat", {16'b0, sat_vec}, 32'h0);
    check("conv_valid", {31'b0, valid}, 32'h1);

    // 32-bit accumulator clamp: 8192 products of 2^18 reach 2^31, which must pin at max
    step(M_HOLD, 1'b1);
    set_all(16'h8000, 16'h8000);
    step(M_MUL, 1'b0);
    check("acc_first", {16'b0, lane_res(0)}, 32'h7FFF);
    for (int n = 0; n < 8191; n++) step(M_MAC, 1'b0);
    check("acc_clamp_res", {16'b0, lane_res(0)}, 32'h7FFF);
    check("acc_clamp_sat", {16'b0, sat_vec}, 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_array_16.md
PE_ARRAY_16 -- requirements
Module: pe_array_16

Interface
REQ-001 SHALL have parameter LANES, default 16, number of independent processing lanes.
REQ-002 SHALL have parameter DW, default `DATA_WIDTH (16), signed Q4.12 operand/result width.
REQ-003 SHALL have parameter FRAC, default 12, fractional bits (1.0 = 16'h1000).
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator width per lane.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pe_op_mode_in  input  2  `MODE_MUL=2'b00, `MODE_MAC=2'b01, `MODE_ADD=2'b10, `MODE_HOLD=2'b11.
REQ-008 SHALL have port pe_clear_in  input  1  zero all accumulators and flags.
REQ-009 SHALL have port pe_in_a_vec  input  LANES*DW  operand A; lane i at [i*DW +: DW].
REQ-010 SHALL have port pe_in_b_vec  input  LANES*DW  operand B, same packing.
REQ-011 SHALL have port pe_result_vec  output  LANES*DW  per-lane saturated accumulator value.
REQ-012 SHALL have port pe_sat_vec  output  LANES  per-lane sticky saturation flag.
REQ-013 SHALL have port pe_result_valid  output  1  accumulators hold the result of at least one operation since the last clear.

Function
REQ-014 SHALL compute per lane p = (a*b + 2^(FRAC-1)) >>> FRAC: full 32-bit signed product, round-half-up, arithmetic shift, sign-extended to ACC_W.
REQ-015 SHALL, when pe_clear_in=1, load acc=0, sat=0, pe_result_valid=0 on the next edge, regardless of mode (clear has priority).
REQ-016 SHALL, when clear=0 and mode=MUL, load acc=p.
REQ-017 SHALL, when clear=0 and mode=MAC, load acc=acc+p.
REQ-018 SHALL, when clear=0 and mode=ADD, load acc=acc+sext(a); b ignored.
REQ-019 SHALL, when clear=0 and mode=HOLD, leave acc, sat and pe_result_valid unchanged.
REQ-020 SHALL clamp the accumulator sum to [-2^31, 2^31-1] on overflow and set that lane's sat flag.
REQ-021 SHALL drive pe_result_vec lane i combinationally from the acc register, clamped to [16'h8000, 16'h7FFF]; pe_result_vec therefore reflects the inputs applied one edge earlier (1-cycle latency).
REQ-022 SHALL set sat[i] on any MUL/MAC/ADD edge whose new acc lies outside the 16-bit range; sat[i] SHALL stay set until clear or reset, even if acc returns in range.
REQ-023 SHALL set pe_result_valid=1 on any MUL/MAC/ADD edge with clear=0.
REQ-024 SHALL make all lanes fully independent; saturation in one lane SHALL NOT affect others.
REQ-025 SHALL accept a new operation every cycle (no stall, no backpressure).
REQ-026 SHALL treat MAC with a=0 or b=0 as a pure hold of the acc value (p=0).

Reset
REQ-027 SHALL, on reset=1 at a rising edge, load all acc=0, pe_sat_vec=0 and pe_result_valid=0, so that pe_result_vec=0; reset has priority over clear and mode.
REQ-028 SHALL, when reset is asserted mid-sequence, discard the in-flight accumulation; the first post-reset operation starts from acc=0.

Verification
REQ-029 SHALL pass the bias-load scenario: MUL a=16'h0100, b=16'h1000, then MAC a=16'h1000, b=16'h2000 (lane 0) -> 16'h0100 after edge 1, then 16'h2100; valid=1.
REQ-030 SHALL pass the rounding scenario: MUL a=1, b=16'h0800 -> 16'h0001; MUL a=16'hFFFF, b=16'h0800 -> 16'h0000; MUL a=16'hFFFF, b=16'h0FFF -> 16'hFFFF.
REQ-031 SHALL pass the saturation scenario: MUL a=b=16'h7FFF -> result 16'h7FFF and sat[0]=1; then MUL a=0, b=0 -> result 16'h0000 and sat[0] still 1; then clear -> sat[0]=0.
REQ-032 SHALL pass the conv1d-pattern scenario: clear, MUL bias, 4x MAC, 2x MAC with a=b=0, on all 16 lanes with distinct values -> result equals the golden bias+sum of rounded products, stable through both hold cycles.
REQ-033 SHALL pass the priority scenario: clear=1 with mode=MAC and nonzero operands -> acc=0 and valid=0; reset=1 with clear=0 and mode=MUL -> all outputs 0.
REQ-034 SHALL pass the HOLD/ADD scenario: MUL to give 16'h0400, then HOLD with a=16'h7FFF -> 16'h0400, then ADD a=16'h0100 -> 16'h0500.
